// File: rtl/fwd_scoreboard.sv
// Register-hazard scoreboard and forwarding network for the in-order pipeline stages after ID.
// Optional counters (stall_cnt, fwd_cnt, hold_cnt) are compiled in with `define FWD_STATS_EN.
module fwd_scoreboard #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STAGES     = 3,
    parameter int READ_PORTS = 2,
    parameter int LOAD_READY = 1,
    parameter int SRC_W      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         hold,
    input  logic [STAGES-1:0]            flush_mask,
    input  logic                         in_valid,
    input  logic                         in_wen,
    input  logic [ADDR_W-1:0]            in_addr,
    input  logic                         in_is_load,
    output logic                         in_accept,
    input  logic [STAGES*DATA_W-1:0]     stage_data,
    input  logic [READ_PORTS-1:0]        rd_en,
    input  logic [READ_PORTS*ADDR_W-1:0] rd_addr,
    input  logic [READ_PORTS*DATA_W-1:0] rd_regdata,
    output logic [READ_PORTS*DATA_W-1:0] rd_data,
    output logic [READ_PORTS*SRC_W-1:0]  rd_src,
    output logic                         stall_req,
`ifdef FWD_STATS_EN
    output logic [31:0]                  stall_cnt,
    output logic [31:0]                  fwd_cnt,
    output logic [31:0]                  hold_cnt,
`endif
    output logic [STAGES-1:0]            stage_valid
);

    logic [STAGES-1:0]     v_q;
    logic [STAGES-1:0]     wen_q;
    logic [STAGES-1:0]     ld_q;
    logic [ADDR_W-1:0]     addr_q [STAGES];
    logic [STAGES-1:0]     v_next;
    logic [READ_PORTS-1:0] hit;
    logic [READ_PORTS-1:0] haz;

    // Scan from EXE outward; the first match is the youngest producer and masks all older ones.
    always_comb begin
        rd_data = rd_regdata;
        rd_src  = '0;
        hit     = '0;
        haz     = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            for (int k = 0; k < STAGES; k++) begin
                if (!hit[p] && rd_en[p] && v_q[k] && wen_q[k] &&
                    addr_q[k] == rd_addr[p*ADDR_W +: ADDR_W] &&
                    rd_addr[p*ADDR_W +: ADDR_W] != '0) begin
                    hit[p] = 1'b1;
                    if (!ld_q[k] || k >= LOAD_READY) begin
                        rd_data[p*DATA_W +: DATA_W] = stage_data[k*DATA_W +: DATA_W];
                        rd_src[p*SRC_W +: SRC_W]    = SRC_W'(k + 1);
                    end else begin
                        haz[p] = 1'b1;
                    end
                end
            end
        end
    end

    assign stall_req   = |haz;
    // Handshake: the ID instruction enters stage 0 on an edge where in_valid & in_accept are both high.
    assign in_accept   = ~hold & ~stall_req;
    assign stage_valid = v_q;

    // Flush is applied after the hold/shift choice, so a held entry can still be squashed.
    always_comb begin
        v_next    = '0;
        v_next[0] = (hold ? v_q[0] : (in_valid & ~stall_req)) & ~flush_mask[0];
        for (int k = 1; k < STAGES; k++) begin
            v_next[k] = (hold ? v_q[k] : v_q[k-1]) & ~flush_mask[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            wen_q <= '0;
            ld_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                addr_q[k] <= '0;
            end
        end else begin
            v_q <= v_next;
            if (!hold) begin
                wen_q     <= {wen_q[STAGES-2:0], in_wen};
                ld_q      <= {ld_q[STAGES-2:0], in_is_load};
                addr_q[0] <= in_addr;
                for (int k = 1; k < STAGES; k++) begin
                    addr_q[k] <= addr_q[k-1];
                end
            end
        end
    end

`ifdef FWD_STATS_EN
    logic [31:0] fwd_inc;

    always_comb begin
        fwd_inc = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            if (rd_src[p*SRC_W +: SRC_W] != '0) begin
                fwd_inc = fwd_inc + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
            hold_cnt  <= '0;
        end else begin
            if (stall_req && !hold) stall_cnt <= stall_cnt + 32'd1;
            if (in_accept)          fwd_cnt   <= fwd_cnt + fwd_inc;
            if (hold)               hold_cnt  <= hold_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised register-hazard tracker and forwarding network for the in-order MIPS pipeline.
- Records every instruction that leaves ID as it moves through STAGES downstream stages (default EXE, MEM, WB).
- Resolves each ID register read to the youngest in-flight producer, or to the regfile.
- Raises a load-use stall and inserts the EXE bubble itself; no hand-coded forwarding selects or separate hazard logic are needed.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width; address 0 is hard-wired zero and never forwarded
STAGES, 3, number of tracked stages after ID; index 0 = EXE, STAGES-1 = WB; range 2..8
READ_PORTS, 2, number of ID read ports (rs, rt, ...); range 1..4
LOAD_READY, 1, first stage index at which load data is forwardable; range 1..STAGES-1
SRC_W, 4, width of rd_src per port; must hold STAGES

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
hold  in  1  freeze all stage entries (memory wait); flushes still apply
flush_mask  in  STAGES  per-stage squash; bit k invalidates the entry landing in stage k at this edge
in_valid  in  1  ID holds a valid instruction that is ready to advance
in_wen  in  1  ID instruction writes a register
in_addr  in  ADDR_W  ID destination register
in_is_load  in  1  ID instruction is a load
in_accept  out  1  ID advances this cycle (= ~hold & ~stall_req)
stage_data  in  STAGES*DATA_W  result currently produced by stage k, at slice [k*DATA_W +: DATA_W]
rd_en  in  READ_PORTS  port p actually reads its register
rd_addr  in  READ_PORTS*ADDR_W  read addresses
rd_regdata  in  READ_PORTS*DATA_W  regfile read data
rd_data  out  READ_PORTS*DATA_W  resolved operand per port
rd_src  out  READ_PORTS*SRC_W  0 = regfile, k+1 = forwarded from stage k
stall_req  out  1  load-use hazard present
stage_valid  out  STAGES  entry-valid flags, for debug and hazard visibility

Behaviour:
- Per-stage state: valid, wen, addr, is_load. No data is stored; forwarded values always come from stage_data.
- Reset: all state cleared. Outputs after reset: stage_valid=0, stall_req=0, rd_src=0, rd_data=rd_regdata, in_accept=~hold.
- Update precedence: rst, then hold, then shift.
  - hold=1: every stage keeps its entry.
  - hold=0: stage k loads stage k-1.
  - hold=0, stage 0: loads {in_valid & ~stall_req, in_wen, in_addr, in_is_load}. When stall_req=1 a bubble (valid=0) enters stage 0.
  - After the hold/shift selection, the landing entry's valid is ANDed with ~flush_mask[k], for every k, in the same edge.
- Entry leaving stage STAGES-1 is dropped; the regfile write happens outside this block.
- Match rules (combinational), for port p and stage k:
  - match(p,k) = rd_en[p] & valid[k] & wen[k] & addr[k]==rd_addr[p] & rd_addr[p]!=0.
  - ready(k) = ~is_load[k] | (k >= LOAD_READY).
- Youngest match wins, i.e. the lowest k.
  - Youngest match exists and is ready: rd_data = stage_data[k], rd_src = k+1.
  - No match: rd_data = rd_regdata, rd_src = 0.
  - Youngest match not ready: port is hazarded. rd_data = rd_regdata, rd_src = 0 (don't-care). Older matches are ignored.
- stall_req = OR over ports of hazarded. It is independent of hold and in_valid.
- The regfile is write-at-edge, so a WB-stage match is forwarded like any other stage. This covers same-cycle write/read.
- Latency: forwarding is zero-cycle combinational. Scoreboard update is one edge.

Optional Feature:
- Macro: FWD_STATS_EN.
- When defined, adds outputs stall_cnt[31:0], fwd_cnt[31:0], hold_cnt[31:0], each a wrapping counter cleared by rst:
  - stall_cnt increments on each cycle with stall_req & ~hold.
  - fwd_cnt increments by the number of ports with rd_src!=0 on cycles where in_accept=1.
  - hold_cnt increments on each hold cycle.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Back-to-back ALU hazard (defaults).
   - Stimulus: accept add $3 (wen, addr 3); next cycle rd_addr[0]=3, stage_data[0]=0x1234.
   - Required: rd_data[0]=0x1234, rd_src[0]=1, stall_req=0.
2. Load-use hazard.
   - Stimulus: accept lw $4; next cycle read $4.
   - Required: stall_req=1, in_accept=0; after the edge, stage_valid=3'b010.
   - Then: read $4 with stage_data[1]=0xCAFE gives rd_src=2, rd_data=0xCAFE, stall_req=0.
3. Youngest-wins.
   - Stimulus: $5 written by entries in stage 2 (data 0x1) and stage 0 (data 0x2).
   - Required: rd_data=0x2, rd_src=1. With the stage 0 entry not writing (wen=0): rd_data=0x1, rd_src=3.
4. Zero register and rd_en.
   - Stimulus: in-flight write to $0; read $0, rd_regdata=0.
   - Required: rd_src=0, rd_data=0.
   - Also: a matching read with rd_en=0 gives no stall and rd_src=0.
5. Hold with simultaneous flush.
   - Stimulus: entries in all three stages; hold=1, flush_mask=3'b001 for one edge.
   - Required: stage_valid goes 3'b111 to 3'b110, and entries do not shift.
   - Then: hold=0, in_valid=1 gives stage_valid=3'b101 after the next edge.
6. Reset mid-stall.
   - Stimulus: rst=1 during a load-use stall.
   - Required: next cycle stage_valid=0, stall_req=0, rd_src=0. With FWD_STATS_EN, stall_cnt=0.
